// File: rtl/ctrl_pkg.sv
// Shared opcode map, ALU op classes and the per-stage control bundle types
// used by the pipeline control unit and its decoder.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_BR    = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_PASS  = 2'b11;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       link;
        logic       pc_a;
        logic [1:0] aluop;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_NOP = '0;

    typedef struct packed {
        logic memtoreg;
        logic memwrite;
        logic regwrite;
        logic link;
    } mem_bundle_t;

    typedef struct packed {
        logic memtoreg;
        logic regwrite;
        logic link;
    } wb_bundle_t;

    localparam mem_bundle_t MEM_NOP = '0;
    localparam wb_bundle_t  WB_NOP  = '0;

    function automatic mem_bundle_t to_mem(input ctrl_bundle_t c);
        mem_bundle_t m;
        m.memtoreg = c.memtoreg;
        m.memwrite = c.memwrite;
        m.regwrite = c.regwrite;
        m.link     = c.link;
        return m;
    endfunction

    function automatic wb_bundle_t to_wb(input mem_bundle_t m);
        wb_bundle_t w;
        w.memtoreg = m.memtoreg;
        w.regwrite = m.regwrite;
        w.link     = m.link;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Purpose: opcode -> control bundle plus source-register usage flags.
// Latency: purely combinational.
// Backpressure: none; stateless.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int EXT_OPS = 1
) (
    input  logic [6:0]   opcode,
    output ctrl_bundle_t ctrl,
    output logic         uses_rs1,
    output logic         uses_rs2
);

    always_comb begin
        ctrl     = CTRL_NOP;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_LOAD: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_ADD;
                uses_rs1      = 1'b1;
            end
            OP_STORE: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.aluop    = ALU_ADD;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_R: begin
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_FUNCT;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.aluop    = ALU_BR;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_IALU: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALU_ADD;
                uses_rs1      = 1'b1;
            end
            // The extended set falls back to the all-zero NOP bundle when disabled.
            OP_JAL: begin
                if (EXT_OPS != 0) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.jump     = 1'b1;
                    ctrl.link     = 1'b1;
                end
            end
            OP_JALR: begin
                if (EXT_OPS != 0) begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.jump     = 1'b1;
                    ctrl.jalr     = 1'b1;
                    ctrl.link     = 1'b1;
                    uses_rs1      = 1'b1;
                end
            end
            OP_LUI: begin
                if (EXT_OPS != 0) begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = ALU_PASS;
                end
            end
            OP_AUIPC: begin
                if (EXT_OPS != 0) begin
                    ctrl.alusrc   = 1'b1;
                    ctrl.regwrite = 1'b1;
                    ctrl.pc_a     = 1'b1;
                    ctrl.aluop    = ALU_ADD;
                end
            end
            default: begin
                ctrl = CTRL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Purpose: decode ID opcode and carry control through ID/EX, EX/MEM, MEM/WB; owns stall/bubble/flush.
// Latency: ex_* 1 cycle after capture, mem_* 2, wb_* 3; stall/flush outputs are combinational.
// Backpressure: ext_stall freezes every stage register and the bubble counter.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = 5,
    parameter int EXT_OPS      = 1,
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic [6:0]              id_opcode,
    input  logic [REG_ADDR_W-1:0]   id_rs1,
    input  logic [REG_ADDR_W-1:0]   id_rs2,
    input  logic [REG_ADDR_W-1:0]   id_rd,
    input  logic                    ex_branch_taken,
    input  logic                    ext_stall,
    output logic                    stall_if_id,
    output logic                    flush_if_id,
    output logic                    ex_alusrc,
    output logic                    ex_memtoreg,
    output logic                    ex_memwrite,
    output logic                    ex_regwrite,
    output logic                    ex_branch,
    output logic                    ex_jump,
    output logic                    ex_jalr,
    output logic                    ex_link,
    output logic                    ex_pc_a,
    output logic [1:0]              ex_aluop,
    output logic [REG_ADDR_W-1:0]   ex_rd,
    output logic                    mem_memtoreg,
    output logic                    mem_memwrite,
    output logic                    mem_regwrite,
    output logic                    mem_link,
    output logic [REG_ADDR_W-1:0]   mem_rd,
    output logic                    wb_memtoreg,
    output logic                    wb_regwrite,
    output logic                    wb_link,
    output logic [REG_ADDR_W-1:0]   wb_rd,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

    ctrl_bundle_t            id_ctrl;
    logic                    uses_rs1;
    logic                    uses_rs2;
    logic                    load_use;

    ctrl_bundle_t            ex_q;
    logic [REG_ADDR_W-1:0]   ex_rd_q;
    mem_bundle_t             mem_q;
    logic [REG_ADDR_W-1:0]   mem_rd_q;
    wb_bundle_t              wb_q;
    logic [REG_ADDR_W-1:0]   wb_rd_q;
    logic [BUBBLE_CNT_W-1:0] bubble_q;

    ctrl_decode #(
        .EXT_OPS (EXT_OPS)
    ) u_decode (
        .opcode   (id_opcode),
        .ctrl     (id_ctrl),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    // A NOP in EX has memtoreg=0, so it can never look like a hazard source.
    always_comb begin
        load_use = id_valid & ex_q.memtoreg & ex_q.regwrite & (ex_rd_q != '0) &
                   ((uses_rs1 & (ex_rd_q == id_rs1)) | (uses_rs2 & (ex_rd_q == id_rs2)));
        stall_if_id = ext_stall | (load_use & ~ex_branch_taken);
        flush_if_id = ex_branch_taken & ~ext_stall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= CTRL_NOP;
            ex_rd_q  <= '0;
            mem_q    <= MEM_NOP;
            mem_rd_q <= '0;
            wb_q     <= WB_NOP;
            wb_rd_q  <= '0;
            bubble_q <= '0;
        end else if (!ext_stall) begin
            mem_q    <= to_mem(ex_q);
            mem_rd_q <= ex_rd_q;
            wb_q     <= to_wb(mem_q);
            wb_rd_q  <= mem_rd_q;
            if (ex_branch_taken) begin
                ex_q    <= CTRL_NOP;
                ex_rd_q <= '0;
            end else if (load_use) begin
                ex_q    <= CTRL_NOP;
                ex_rd_q <= '0;
                if (bubble_q != '1) begin
                    bubble_q <= bubble_q + BUBBLE_CNT_W'(1);
                end
            end else if (!id_valid) begin
                ex_q    <= CTRL_NOP;
                ex_rd_q <= '0;
            end else begin
                ex_q    <= id_ctrl;
                ex_rd_q <= id_rd;
            end
        end
    end

    assign ex_alusrc    = ex_q.alusrc;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_branch    = ex_q.branch;
    assign ex_jump      = ex_q.jump;
    assign ex_jalr      = ex_q.jalr;
    assign ex_link      = ex_q.link;
    assign ex_pc_a      = ex_q.pc_a;
    assign ex_aluop     = ex_q.aluop;
    assign ex_rd        = ex_rd_q;

    assign mem_memtoreg = mem_q.memtoreg;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_link     = mem_q.link;
    assign mem_rd       = mem_rd_q;

    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_link      = wb_q.link;
    assign wb_rd        = wb_rd_q;

    assign bubble_cnt   = bubble_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Drives three parameter variants of pipe_ctrl_unit with shared stimulus and
// compares them each cycle against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken;
    logic       ext_stall;

    // ex: {alusrc,memtoreg,memwrite,regwrite,branch,jump,jalr,link,pc_a,aluop[1:0],rd[4:0]}
    logic [15:0] d_ex  [3];
    // mem: {memtoreg,memwrite,regwrite,link,rd}; wb: {memtoreg,regwrite,link,rd}
    logic [8:0]  d_mem [3];
    logic [7:0]  d_wb  [3];
    logic [15:0] d_bc  [3];
    logic        d_stall [3];
    logic        d_flush [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int EXT = (g == 1) ? 0 : 1;
        localparam int BW  = (g == 2) ? 2 : 16;
        logic [BW-1:0] bc;
        pipe_ctrl_unit #(
            .REG_ADDR_W   (5),
            .EXT_OPS      (EXT),
            .BUBBLE_CNT_W (BW)
        ) dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .id_valid        (id_valid),
            .id_opcode       (id_opcode),
            .id_rs1          (id_rs1),
            .id_rs2          (id_rs2),
            .id_rd           (id_rd),
            .ex_branch_taken (ex_branch_taken),
            .ext_stall       (ext_stall),
            .stall_if_id     (d_stall[g]),
            .flush_if_id     (d_flush[g]),
            .ex_alusrc       (d_ex[g][15]),
            .ex_memtoreg     (d_ex[g][14]),
            .ex_memwrite     (d_ex[g][13]),
            .ex_regwrite     (d_ex[g][12]),
            .ex_branch       (d_ex[g][11]),
            .ex_jump         (d_ex[g][10]),
            .ex_jalr         (d_ex[g][9]),
            .ex_link         (d_ex[g][8]),
            .ex_pc_a         (d_ex[g][7]),
            .ex_aluop        (d_ex[g][6:5]),
            .ex_rd           (d_ex[g][4:0]),
            .mem_memtoreg    (d_mem[g][8]),
            .mem_memwrite    (d_mem[g][7]),
            .mem_regwrite    (d_mem[g][6]),
            .mem_link        (d_mem[g][5]),
            .mem_rd          (d_mem[g][4:0]),
            .wb_memtoreg     (d_wb[g][7]),
            .wb_regwrite     (d_wb[g][6]),
            .wb_link         (d_wb[g][5]),
            .wb_rd           (d_wb[g][4:0]),
            .bubble_cnt      (bc)
        );
        assign d_bc[g] = 16'(bc);
    end

    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RR = 7'b0110011,
                           BR = 7'b1100011, IA = 7'b0010011, JL = 7'b1101111,
                           JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111;

    // Model: each stage holds just the instruction (opcode, rd); opcode 0 = bubble.
    int         m_ext [3] = '{1, 0, 1};
    int         m_max [3] = '{65535, 65535, 3};
    logic [6:0] m_op  [3][3];
    logic [4:0] m_rd  [3][3];
    int         m_cnt [3];

    // Bundle bits: {alusrc,memtoreg,memwrite,regwrite,branch,jump,jalr,link,pc_a,aluop}
    function automatic logic [10:0] ref_bundle(input int ext, input logic [6:0] op);
        case (op)
            LD: return 11'b1_1_0_1_0_0_0_0_0_00;
            ST: return 11'b1_0_1_0_0_0_0_0_0_00;
            RR: return 11'b0_0_0_1_0_0_0_0_0_10;
            BR: return 11'b0_0_0_0_1_0_0_0_0_01;
            IA: return 11'b1_0_0_1_0_0_0_0_0_00;
            JL: return (ext != 0) ? 11'b0_0_0_1_0_1_0_1_0_00 : 11'b0;
            JR: return (ext != 0) ? 11'b1_0_0_1_0_1_1_1_0_00 : 11'b0;
            LU: return (ext != 0) ? 11'b1_0_0_1_0_0_0_0_0_11 : 11'b0;
            AU: return (ext != 0) ? 11'b1_0_0_1_0_0_0_0_1_00 : 11'b0;
            default: return 11'b0;
        endcase
    endfunction

    function automatic bit model_lu(input int k);
        logic [10:0] b;
        bit u1, u2;
        b  = ref_bundle(m_ext[k], m_op[k][0]);
        u1 = (ref_bundle(m_ext[k], id_opcode) != 0) && !(id_opcode inside {JL, LU, AU});
        u2 = id_opcode inside {RR, ST, BR};
        return id_valid && b[9] && b[7] && (m_rd[k][0] != 0) &&
               ((u1 && m_rd[k][0] == id_rs1) || (u2 && m_rd[k][0] == id_rs2));
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            for (int s = 0; s < 3; s++) begin
                m_op[k][s] = '0;
                m_rd[k][s] = '0;
            end
        end
    endtask

    task automatic model_check();
        logic [10:0] b0, b1, b2;
        bit lu;
        for (int k = 0; k < 3; k++) begin
            b0 = ref_bundle(m_ext[k], m_op[k][0]);
            b1 = ref_bundle(m_ext[k], m_op[k][1]);
            b2 = ref_bundle(m_ext[k], m_op[k][2]);
            lu = model_lu(k);
            chk("stall", k, 32'(d_stall[k]), 32'(ext_stall | (lu & ~ex_branch_taken)));
            chk("flush", k, 32'(d_flush[k]), 32'(ex_branch_taken & ~ext_stall));
            chk("ex",    k, 32'(d_ex[k]),  32'({b0, m_rd[k][0]}));
            chk("mem",   k, 32'(d_mem[k]), 32'({b1[9], b1[8], b1[7], b1[3], m_rd[k][1]}));
            chk("wb",    k, 32'(d_wb[k]),  32'({b2[9], b2[7], b2[3], m_rd[k][2]}));
            chk("bubble", k, 32'(d_bc[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic model_advance();
        bit lu;
        for (int k = 0; k < 3; k++) begin
            lu = model_lu(k);
            if (!ext_stall) begin
                m_op[k][2] = m_op[k][1]; m_rd[k][2] = m_rd[k][1];
                m_op[k][1] = m_op[k][0]; m_rd[k][1] = m_rd[k][0];
                if (ex_branch_taken || lu || !id_valid) begin
                    m_op[k][0] = '0; m_rd[k][0] = '0;
                    if (!ex_branch_taken && lu && m_cnt[k] < m_max[k]) m_cnt[k]++;
                end else begin
                    m_op[k][0] = id_opcode; m_rd[k][0] = id_rd;
                end
            end
        end
    endtask

    // Called at posedge+1 with inputs already set; returns at the next posedge+1.
    task automatic step();
        if (!rst_n) model_clear();
        #1;
        model_check();
        if (rst_n) model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input logic [6:0] op, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input bit br, input bit stl);
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        ex_branch_taken = br; ext_stall = stl;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [6:0] ops [10];
        ops = '{LD, ST, RR, BR, IA, JL, JR, LU, AU, 7'b1110011};
        rst_n = 1'b0;
        set_in(0, 7'd0, 0, 0, 0, 0, 0);
        model_clear();
        @(posedge clk); #1;
        step();
        step();
        rst_n = 1'b1;

        // R-type rd=3 flows EX -> MEM -> WB
        set_in(1, RR, 1, 2, 3, 0, 0); step();
        set_in(0, 7'd0, 0, 0, 0, 0, 0);
        chk("r_ex_regwrite", 0, 32'(d_ex[0][12]), 1);
        chk("r_ex_aluop", 0, 32'(d_ex[0][6:5]), 2);
        chk("r_ex_rd", 0, 32'(d_ex[0][4:0]), 3);
        step(); step();
        chk("r_wb", 0, 32'(d_wb[0]), 32'({3'b010, 5'd3}));
        step();

        // load rd=5 then R rs2=5: one bubble
        set_in(1, LD, 1, 0, 5, 0, 0); step();
        set_in(1, RR, 7, 5, 8, 0, 0); #1;
        chk("lu_stall", 0, 32'(d_stall[0]), 1);
        step();
        chk("lu_ex_nop", 0, 32'(d_ex[0]), 0);
        chk("lu_bubble", 0, 32'(d_bc[0]), 1);
        #1;
        chk("lu_stall_clear", 0, 32'(d_stall[0]), 0);
        step();
        chk("lu_r_in_ex", 0, 32'(d_ex[0][4:0]), 8);

        // load rd=0 never hazards; LUI uses no source
        set_in(1, LD, 1, 0, 0, 0, 0); step();
        set_in(1, RR, 0, 0, 9, 0, 0); #1;
        chk("rd0_no_stall", 0, 32'(d_stall[0]), 0);
        step();
        set_in(1, LD, 1, 0, 5, 0, 0); step();
        set_in(1, LU, 5, 5, 6, 0, 0); #1;
        chk("lui_no_stall", 0, 32'(d_stall[0]), 0);
        step();
        chk("no_extra_bubble", 0, 32'(d_bc[0]), 1);

        // external freeze with load in EX/MEM
        set_in(1, LD, 2, 0, 9, 0, 0); step();
        set_in(0, 7'd0, 0, 0, 0, 0, 0); step();
        set_in(1, RR, 9, 1, 10, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("frz_mem", 0, 32'(d_mem[0]), 32'({4'b1010, 5'd9}));
            chk("frz_bubble", 0, 32'(d_bc[0]), 1);
        end
        set_in(1, RR, 9, 1, 10, 0, 0); step();
        chk("frz_release_wb", 0, 32'(d_wb[0]), 32'({3'b110, 5'd9}));
        chk("frz_release_ex", 0, 32'(d_ex[0][4:0]), 10);
        set_in(0, 7'd0, 0, 0, 0, 0, 0); step();

        // branch taken wins over load-use
        set_in(1, LD, 1, 0, 5, 0, 0); step();
        set_in(1, RR, 1, 5, 11, 1, 0); #1;
        chk("br_flush", 0, 32'(d_flush[0]), 1);
        chk("br_no_stall", 0, 32'(d_stall[0]), 0);
        step();
        chk("br_ex_nop", 0, 32'(d_ex[0]), 0);
        chk("br_bubble", 0, 32'(d_bc[0]), 1);

        // extended opcodes
        set_in(1, JL, 0, 0, 1, 0, 0); step();
        chk("jal_noext", 1, 32'(d_ex[1][15:5]), 0);
        chk("jal_ext_jump", 0, 32'(d_ex[0][10]), 1);
        set_in(1, JR, 2, 0, 4, 0, 0); step();
        chk("jalr_ext", 0, 32'(d_ex[0][15:5]), 32'(11'b1_0_0_1_0_1_1_1_0_00));

        // five more load-use events: 2-bit counter saturates
        for (int i = 0; i < 5; i++) begin
            set_in(1, LD, 0, 0, 5, 0, 0); step();
            set_in(1, RR, 5, 0, 7, 0, 0); step(); step();
        end
        chk("sat_bubble", 2, 32'(d_bc[2]), 3);
        chk("wide_bubble", 0, 32'(d_bc[0]), 6);

        // reset in the middle of a freeze drops everything
        set_in(1, LD, 1, 0, 3, 0, 0); step();
        set_in(1, RR, 3, 0, 4, 0, 1); step();
        rst_n = 1'b0; step();
        chk("rst_ex", 0, 32'(d_ex[0]), 0);
        chk("rst_bubble", 0, 32'(d_bc[0]), 0);
        rst_n = 1'b1;
        set_in(0, 7'd0, 0, 0, 0, 0, 0); step();

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_in($urandom_range(0, 9) != 0, ops[$urandom_range(0, 9)],
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised successor to the single-cycle decoder. It decodes the ID-stage opcode, including the optional JAL/JALR/LUI/AUIPC set, into a control bundle. It carries that bundle through ID/EX, EX/MEM and MEM/WB registers, and itself detects load-use hazards, branch flushes and external freezes. It sits between the IF/ID register and the datapath and is the single owner of stall/bubble/flush decisions.

Parameters:
REG_ADDR_W, 5, register index width for rs1/rs2/rd.
EXT_OPS, 1, 1 = decode JAL/JALR/LUI/AUIPC; 0 = those opcodes decode as NOP bundle.
BUBBLE_CNT_W, 16, width of saturating inserted-bubble counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_opcode  in  7  instruction[6:0] in ID
id_rs1  in  REG_ADDR_W  source 1 index
id_rs2  in  REG_ADDR_W  source 2 index
id_rd  in  REG_ADDR_W  destination index
ex_branch_taken  in  1  branch/jump resolved taken in EX
ext_stall  in  1  memory/system freeze of whole pipe
stall_if_id  out  1  hold PC and IF/ID (combinational)
flush_if_id  out  1  clear IF/ID (combinational)
ex_alusrc, ex_memtoreg, ex_memwrite, ex_regwrite, ex_branch, ex_jump, ex_jalr, ex_link, ex_pc_a  out  1 each  ID/EX bundle
ex_aluop  out  2  ID/EX ALU op class
ex_rd  out  REG_ADDR_W  ID/EX destination
mem_memtoreg, mem_memwrite, mem_regwrite, mem_link  out  1 each  EX/MEM bundle
mem_rd  out  REG_ADDR_W  EX/MEM destination
wb_memtoreg, wb_regwrite, wb_link  out  1 each  MEM/WB bundle
wb_rd  out  REG_ADDR_W  MEM/WB destination
bubble_cnt  out  BUBBLE_CNT_W  saturating count of load-use bubbles

Behaviour:
- Decode is combinational. Unlisted fields = 0; no X ever driven.
  - 0000011 load: alusrc, memtoreg, regwrite, aluop=00
  - 0100011 store: alusrc, memwrite, aluop=00
  - 0110011 R: regwrite, aluop=10
  - 1100011 branch: branch, aluop=01
  - 0010011 I-ALU: alusrc, regwrite, aluop=00
  - EXT_OPS only: 1101111 JAL: regwrite, jump, link
  - EXT_OPS only: 1100111 JALR: alusrc, regwrite, jump, jalr, link
  - EXT_OPS only: 0110111 LUI: alusrc, regwrite, aluop=11
  - EXT_OPS only: 0010111 AUIPC: alusrc, regwrite, pc_a, aluop=00
  - Any other opcode: NOP bundle (all zero).
- Source use:
  - uses_rs1 = all decoded ops except JAL, LUI, AUIPC, NOP.
  - uses_rs2 = R, store, branch.
- load_use = id_valid & ex_memtoreg & ex_regwrite & (ex_rd != 0) & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- stall_if_id = ext_stall | (load_use & ~ex_branch_taken).
- flush_if_id = ex_branch_taken & ~ext_stall.
- Register update on rising clk, priority order:
  1. ext_stall: all three stage registers and bubble_cnt hold.
  2. ex_branch_taken: ID/EX <= NOP bundle, rd=0. EX/MEM <= ID/EX and MEM/WB <= EX/MEM (the branch itself proceeds).
  3. load_use: ID/EX <= NOP; bubble_cnt += 1, saturating at all-ones. EX/MEM and MEM/WB advance.
  4. !id_valid: ID/EX <= NOP.
  5. Otherwise ID/EX <= decoded bundle with rd = id_rd.
- Latency: a decoded instruction appears on ex_* 1 cycle after capture, mem_* after 2, wb_* after 3.
- Reset (async, rst_n=0): every stage bundle, every *_rd and bubble_cnt = 0 immediately. stall_if_id and flush_if_id follow their equations. A reset mid-stall drops all in-flight state.
- A NOP bundle is never counted as a hazard source.

Decomposition:
- ctrl_pkg holds:
  - opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_IALU, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - aluop encodings (ALU_ADD=00, ALU_BR=01, ALU_FUNCT=10, ALU_PASS=11)
  - packed ctrl_bundle_t typedef and CTRL_NOP constant
- One sub-module, ctrl_decode: combinational opcode -> ctrl_bundle_t, uses_rs1, uses_rs2, parametrised by EXT_OPS.

Test Plan:
- Reset then release: all outputs 0, bubble_cnt=0; issue R-type rd=3 -> ex_regwrite=1, ex_aluop=10, ex_rd=3 after 1 cycle; wb_regwrite=1, wb_rd=3 after 3 cycles.
- Load rd=5, then R-type rs2=5 -> stall_if_id=1 for exactly 1 cycle, ex_* NOP, bubble_cnt=1; next cycle the R-type reaches EX.
- Load rd=0, then R-type rs1=0 -> no stall, bubble_cnt unchanged; load rd=5, then LUI rd=6 -> no stall (LUI uses no source).
- ext_stall held 3 cycles with load in EX/MEM -> all stage outputs frozen, bubble_cnt frozen; release resumes with no lost or duplicated instruction.
- ex_branch_taken coincident with a load-use condition -> flush_if_id=1, stall_if_id=0, ID/EX NOP, bubble_cnt unchanged.
- EXT_OPS=0: JAL opcode -> ex bundle all zero. EXT_OPS=1: JALR -> ex_jump=ex_jalr=ex_link=ex_alusrc=ex_regwrite=1. BUBBLE_CNT_W=2: 5 load-use events -> bubble_cnt=3.
